// File: rtl/spi_ram_slave_param_if.sv
// SPI slave pin bundle: slave select, serial data in/out, and status flags.
// Latency: none, this is wiring only.
// Backpressure: none; SPI has no flow control, the master owns SS_n timing.
//
// Ports: SS_n (select, active low), MOSI (serial in), MISO (serial out),
//        busy (frame in progress), frame_err (one-cycle malformed-frame pulse).
interface spi_ram_slave_param_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic frame_err;

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output busy,
        output frame_err
    );

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  busy,
        input  frame_err
    );
endinterface

// File: rtl/spi_ram_slave_param.sv
// SPI slave frame decoder with write/read address registers and a sync RAM.
// Latency: address/data update on the last payload edge; read MSB on MISO 2 edges after last dummy bit.
// Backpressure: none; SS_n high aborts any frame on the next edge, discarding partial payload.
//
// Ports: clk, rst (async active-high), bus (slave modport: SS_n, MOSI, MISO, busy, frame_err).
// Optional macro SPI_BURST_EN: data frames keep writing/streaming consecutive words
// with address auto-increment (wrapping at MEM_DEPTH-1) while SS_n stays low.
module spi_ram_slave_param #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_ram_slave_param_if.slave  bus
);

    localparam int SH_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(SH_W + 2);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]    DATA_END  = CNT_W'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, GET_CMD, WRITE, READ_ADD, READ_DATA, SEND, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SH_W-2:0]        sh_q, sh_d;       // previously received payload bits
    logic [SH_W-1:0]        sh_in;            // payload including the bit on MOSI now
    logic                   path_q, path_d;   // P bit: 0 write path, 1 read path
    logic                   cmd_q, cmd_d;     // C[1] after first cmd edge, C[0] after second
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;   // read word, shifted out MSB first
    logic                   miso_q, miso_d;
    logic                   ferr_q, ferr_d;
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_wdat;
    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    // Out-of-range reads return zero rather than aliasing into the array.
    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) ? mem_q[a[IDX_W-1:0]] : '0;
    endfunction

`ifdef SPI_BURST_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_WRAP = ADDR_WIDTH'(MEM_DEPTH - 1);

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WRAP) ? '0 : a + 1'b1;
    endfunction
`endif

    assign sh_in = {sh_q, bus.MOSI};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        path_d    = path_q;
        cmd_d     = cmd_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        dout_d    = dout_q;
        miso_d    = 1'b0;
        ferr_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdat  = sh_in[DATA_WIDTH-1:0];

        if (bus.SS_n) begin
            // Deselect aborts silently from any state.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;   // idle cycle, MOSI ignored
                CHK_CMD: begin
                    path_d  = bus.MOSI;
                    cnt_d   = '0;
                    state_d = GET_CMD;
                end
                GET_CMD: begin
                    cmd_d = bus.MOSI;
                    if (cnt_q == '0) begin
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (cmd_q != path_q) begin
                            ferr_d  = 1'b1;
                            state_d = DONE;
                        end else if (!cmd_q) begin
                            state_d = WRITE;
                        end else if (!bus.MOSI) begin
                            state_d = READ_ADD;
                        end else begin
                            state_d = READ_DATA;
                        end
                    end
                end
                WRITE: begin
                    sh_d  = sh_in[SH_W-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (!cmd_q) begin
                        if (cnt_q == ADDR_LAST) begin
                            wr_addr_d = sh_in[ADDR_WIDTH-1:0];
                            state_d   = DONE;
                        end
                    end else if (cnt_q == DATA_LAST) begin
                        mem_we = in_range(wr_addr_q);
`ifdef SPI_BURST_EN
                        wr_addr_d = addr_inc(wr_addr_q);
                        cnt_d     = '0;
`else
                        state_d = DONE;
`endif
                    end
                end
                READ_ADD: begin
                    sh_d  = sh_in[SH_W-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        rd_addr_d = sh_in[ADDR_WIDTH-1:0];
                        state_d   = DONE;
                    end
                end
                READ_DATA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    // cnt 0: RAM read into dout; cnt 1..DATA_WIDTH: one bit out per edge.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        dout_d = rd_word(rd_addr_q);
                    end else if (cnt_q <= DATA_END) begin
                        miso_d = dout_q[DATA_WIDTH-1];
                        dout_d = dout_q << 1;
`ifdef SPI_BURST_EN
                        // Fetch the next word on the last-bit edge so streaming has no gap.
                        if (cnt_q == DATA_END) begin
                            rd_addr_d = addr_inc(rd_addr_q);
                            dout_d    = rd_word(addr_inc(rd_addr_q));
                            cnt_d     = CNT_W'(1);
                        end
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: state_d = DONE;     // trailing MOSI bits ignored
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            path_q    <= 1'b0;
            cmd_q     <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            dout_q    <= '0;
            miso_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            path_q    <= path_d;
            cmd_q     <= cmd_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            dout_q    <= dout_d;
            miso_q    <= miso_d;
            ferr_q    <= ferr_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr_q[IDX_W-1:0]] <= mem_wdat;
        end
    end

    assign bus.MISO      = miso_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.frame_err = ferr_q;

endmodule
